// File: rtl/stream_upsizer.sv
// Packs Ratio narrow beats into one wide word, beat 0 in the LSBs.
// An early last_i emits a partial word. A finished word that cannot be handed over waits in the accumulator.
module stream_upsizer #(
  parameter int DataWidth = 8,
  parameter int Ratio     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DataWidth-1:0]       data_i,
  input  logic                       last_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DataWidth*Ratio-1:0] data_o,
  output logic [Ratio-1:0]           strb_o
);

  localparam int CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int WordW = DataWidth * Ratio;

  logic [WordW-1:0] acc_data_q, acc_data_d;
  logic [Ratio-1:0] acc_strb_q, acc_strb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             acc_full_q, acc_full_d;
  logic [WordW-1:0] out_data_q, out_data_d;
  logic [Ratio-1:0] out_strb_q, out_strb_d;
  logic             out_valid_q, out_valid_d;

  logic [WordW-1:0] beat_data;
  logic [Ratio-1:0] beat_strb;
  logic             out_free;
  logic             accept;
  logic             complete;

  assign ready_o  = !acc_full_q;
  assign valid_o  = out_valid_q;
  assign data_o   = out_data_q;
  assign strb_o   = out_strb_q;

  assign out_free = !out_valid_q || ready_i;
  assign accept   = valid_i && !acc_full_q;
  assign complete = (cnt_q == CntW'(Ratio - 1)) || last_i;

  // Accumulator contents with the incoming beat merged into lane cnt
  always_comb begin
    beat_data = acc_data_q;
    beat_strb = acc_strb_q;
    for (int k = 0; k < Ratio; k++) begin
      if (cnt_q == CntW'(k)) begin
        beat_data[k*DataWidth +: DataWidth] = data_i;
        beat_strb[k]                        = 1'b1;
      end
    end
  end

  always_comb begin
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    cnt_d       = cnt_q;
    acc_full_d  = acc_full_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && ready_i) begin
      out_valid_d = 1'b0;
    end

    if (acc_full_q) begin
      if (out_free) begin
        out_data_d  = acc_data_q;
        out_strb_d  = acc_strb_q;
        out_valid_d = 1'b1;
        acc_data_d  = '0;
        acc_strb_d  = '0;
        cnt_d       = '0;
        acc_full_d  = 1'b0;
      end
    end else if (accept) begin
      if (complete && out_free) begin
        out_data_d  = beat_data;
        out_strb_d  = beat_strb;
        out_valid_d = 1'b1;
        acc_data_d  = '0;
        acc_strb_d  = '0;
        cnt_d       = '0;
      end else if (complete) begin
        acc_data_d  = beat_data;
        acc_strb_d  = beat_strb;
        acc_full_d  = 1'b1;
      end else begin
        acc_data_d  = beat_data;
        acc_strb_d  = beat_strb;
        cnt_d       = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      cnt_q       <= '0;
      acc_full_q  <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      cnt_q       <= cnt_d;
      acc_full_q  <= acc_full_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer (DataWidth=8, Ratio=4).
// Runs a cycle-vector table, hand-written stall/flush/reset sequences, and a random scoreboard run.
module tb_stream_upsizer;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_o, last_i, valid_o, ready_i;
  logic [7:0]  data_i;
  logic [31:0] data_o;
  logic [3:0]  strb_o;

  int vectors    = 0;
  int miscompares = 0;

  stream_upsizer #(.DataWidth(8), .Ratio(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .strb_o  (strb_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic        l;
    logic [7:0]  d;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  es;
    logic        erdy;
  } vec_t;

  vec_t tbl[$];

  // Spec-level model: the list of words the stream should produce
  logic [31:0] exp_d[$];
  logic [3:0]  exp_s[$];
  logic [31:0] cur_word;
  int          cur_n    = 0;
  int          accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [7:0] d,
                       input logic r, input logic f);
    valid_i = v;
    last_i  = l;
    data_i  = d;
    ready_i = r;
    flush_i = f;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic l, input logic [7:0] d, input logic r,
                              input logic ev, input logic [31:0] ed, input logic [3:0] es,
                              input logic erdy);
    vec_t x;
    x.v = v; x.l = l; x.d = d; x.r = r; x.ev = ev; x.ed = ed; x.es = es; x.erdy = erdy;
    return x;
  endfunction

  task automatic model_beat(input logic [7:0] d, input logic l);
    cur_word[cur_n*8 +: 8] = d;
    cur_n++;
    accepted++;
    if (cur_n == 4 || l) begin
      exp_d.push_back(cur_word);
      exp_s.push_back(4'((1 << cur_n) - 1));
      cur_word = '0;
      cur_n    = 0;
    end
  endtask

  // One cycle of the random run: checks ready_o is combinationally independent of the inputs, then scores handshakes
  task automatic monitor_cycle();
    logic sv, sr, sl, r0;
    @(negedge clk_i);
    sv = valid_i; sr = ready_i; sl = last_i; r0 = ready_o;
    valid_i = ~sv; ready_i = ~sr; last_i = ~sl;
    #1;
    chk("ready_o_comb", 32'(ready_o), 32'(r0));
    valid_i = sv; ready_i = sr; last_i = sl;
    #1;
    if (valid_i && ready_o) model_beat(data_i, last_i);
    if (valid_o && ready_i) begin
      if (exp_d.size() == 0) begin
        chk("spurious_word", 32'(valid_o), 32'd0);
      end else begin
        chk("rand_data", data_o, exp_d.pop_front());
        chk("rand_strb", 32'(strb_o), 32'(exp_s.pop_front()));
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    cur_word = '0;
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    rst_i = 1'b0;
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_data", data_o, 32'd0);
    chk("reset_strb", 32'(strb_o), 32'd0);

    // Expected outputs are those seen just after the edge that consumes each row
    tbl.push_back(mk(1, 0, 8'h11, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h22, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h33, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h44, 1, 1, 32'h44332211, 4'hF, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'hAA, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 1, 8'hBB, 1, 1, 32'h0000BBAA, 4'h3, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h01, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h02, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h03, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 1, 8'h04, 1, 1, 32'h04030201, 4'hF, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 1, 8'h5A, 1, 1, 32'h0000005A, 4'h1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h10, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h20, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h30, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h40, 1, 1, 32'h40302010, 4'hF, 1));
    tbl.push_back(mk(1, 0, 8'h50, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h60, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h70, 1, 0, 32'h0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 8'h80, 1, 1, 32'h80706050, 4'hF, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 32'h0, 4'h0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].r, 1'b0);
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(valid_o), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), 32'(ready_o), 32'(tbl[i].erdy));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), data_o, tbl[i].ed);
        chk($sformatf("tbl%0d_strb", i), 32'(strb_o), 32'(tbl[i].es));
      end
    end

    // Stall: word 1 held in the output register, word 2 parked in the accumulator
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      step();
    end
    chk("stall_valid", 32'(valid_o), 32'd1);
    chk("stall_ready", 32'(ready_o), 32'd0);
    chk("stall_data1", data_o, 32'h04030201);
    drive(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    step();
    step();
    chk("stall_hold_data", data_o, 32'h04030201);
    chk("stall_hold_valid", 32'(valid_o), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("stall_word2_valid", 32'(valid_o), 32'd1);
    chk("stall_word2_data", data_o, 32'h08070605);
    chk("stall_word2_strb", 32'(strb_o), 32'hF);
    chk("stall_ready_back", 32'(ready_o), 32'd1);
    step();
    chk("stall_drained", 32'(valid_o), 32'd0);

    // Flush drops the partial word and the beat presented alongside it
    drive(1'b1, 1'b0, 8'hE1, 1'b1, 1'b0); step();
    drive(1'b1, 1'b0, 8'hE2, 1'b1, 1'b0); step();
    drive(1'b1, 1'b0, 8'hE3, 1'b1, 1'b1); step();
    chk("flush_ready", 32'(ready_o), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
      step();
    end
    chk("flush_after_valid", 32'(valid_o), 32'd1);
    chk("flush_after_data", data_o, 32'h04030201);
    chk("flush_after_strb", 32'(strb_o), 32'hF);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();

    // Flush also drops a word waiting in the output register
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 8'h90 + 8'(i), 1'b0, 1'b0);
      step();
    end
    chk("flush_out_pre", 32'(valid_o), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); step();
    chk("flush_out_valid", 32'(valid_o), 32'd0);

    // Reset while a word is held and another parked
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0, 1'b0);
      step();
    end
    chk("rst_pre_valid", 32'(valid_o), 32'd1);
    chk("rst_pre_ready", 32'(ready_o), 32'd0);
    rst_i = 1'b1;
    drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    step();
    rst_i = 1'b0;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_data", data_o, 32'd0);
    chk("rst_strb", 32'(strb_o), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
    chk("rst_no_output", 32'(valid_o), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 8'hD0 + 8'(i), 1'b1, 1'b0);
      step();
    end
    chk("rst_after_data", data_o, 32'hD4D3D2D1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();

    // Random traffic against the scoreboard
    begin
      int cycles = 0;
      while (accepted < 10000 && cycles < 60000) begin
        drive(($urandom_range(99) < 70) ? 1'b1 : 1'b0,
              ($urandom_range(99) < 10) ? 1'b1 : 1'b0,
              8'($urandom_range(255)),
              ($urandom_range(99) < 65) ? 1'b1 : 1'b0, 1'b0);
        monitor_cycle();
        cycles++;
      end
      if (accepted < 10000) chk("rand_budget", 32'(accepted), 32'd10000);
      for (int i = 0; i < 20 && cur_n != 0; i++) begin
        drive(1'b1, 1'b1, 8'($urandom_range(255)), 1'b1, 1'b0);
        monitor_cycle();
      end
      for (int i = 0; i < 20 && exp_d.size() != 0; i++) begin
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        monitor_cycle();
      end
      chk("rand_partial_left", 32'(cur_n), 32'd0);
      chk("rand_words_left", 32'(exp_d.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_upsizer.md
STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 SHALL have parameter DataWidth, default 8, meaning the width in bits of one input beat (>=1).
REQ-002 SHALL have parameter Ratio, default 4, meaning the number of input beats packed into one output word (>=1).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1 bit: discards all buffered data.
REQ-006 SHALL have port valid_i, input, 1 bit: the input beat is valid.
REQ-007 SHALL have port ready_o, output, 1 bit: the block accepts an input beat.
REQ-008 SHALL have port data_i, input, DataWidth bits: the input beat.
REQ-009 SHALL have port last_i, input, 1 bit: closes the current word early (partial word).
REQ-010 SHALL have port valid_o, output, 1 bit: the output word is valid.
REQ-011 SHALL have port ready_i, input, 1 bit: the downstream stage accepts the word.
REQ-012 SHALL have port data_o, output, DataWidth*Ratio bits: the packed word, beat 0 in the LSBs.
REQ-013 SHALL have port strb_o, output, Ratio bits: bit k is set when beat k is present in data_o.

Function
REQ-014 SHALL treat an input beat as accepted when valid_i && ready_o, and an output word as taken when valid_o && ready_i.
REQ-015 SHALL hold an accumulator (data, strb, fill counter cnt from 0 to Ratio-1) and a separate output register.
REQ-016 SHALL write each accepted beat into lane cnt, set strb bit cnt and increment cnt.
REQ-017 SHALL count a beat as completing when cnt==Ratio-1 or last_i==1.
REQ-018 SHALL, on a completing beat with the output register empty or taken in the same cycle, load the output register with the full word in that edge (latency 1 cycle from the last beat) and reset cnt to 0.
REQ-019 SHALL otherwise park the completed word in the accumulator with acc_full=1.
REQ-020 SHALL drive ready_o = !acc_full, derived from registers only, with no combinational path from valid_i, last_i or ready_i.
REQ-021 SHALL, while acc_full=1, move the parked word into the output register on the edge where the output register is empty or taken, then clear acc_full and cnt.
REQ-022 SHALL drive unfilled lanes of data_o to zero; strb_o SHALL be contiguous from bit 0.
REQ-023 SHALL hold data_o and strb_o stable while valid_o && !ready_i, and SHALL NOT drop valid_o before the word is taken.
REQ-024 SHALL sustain full throughput of one beat per cycle when ready_i is held at 1; with Ratio=1 it acts as a one-deep pipeline register.
REQ-025 SHALL, on flush_i=1, clear the accumulator, acc_full, cnt and valid_o at the next edge; flush_i SHALL take priority over acceptance and completion, and a beat presented in the flush cycle SHALL be dropped.
REQ-026 SHALL accept last_i on a beat with cnt==Ratio-1 as a normal full word (strb all ones).

Reset
REQ-027 SHALL, at a rising edge with rst_i=1, set valid_o=0, data_o=0, strb_o=0, cnt=0 and acc_full=0 (so ready_o=1), overriding every other input including flush_i.
REQ-028 SHALL, when reset arrives mid-word or mid-stall, lose all partial and parked data with no output produced.

Structure
REQ-029 SHALL need no shared package; counter width $clog2(Ratio) with a minimum of 1 SHALL be a local parameter.
REQ-030 SHALL be self-contained with no sub-module; it SHALL be usable directly upstream of stream_fifo.

Verification (DataWidth=8, Ratio=4)
REQ-031 SHALL cover: beats 0x11,0x22,0x33,0x44 with ready_i=1 -> one cycle later data_o=0x44332211, strb_o=4'b1111, valid_o high for 1 cycle.
REQ-032 SHALL cover: beats 0xAA,0xBB with last_i on 0xBB -> data_o=0x0000BBAA, strb_o=4'b0011.
REQ-033 SHALL cover: ready_i=0 and 8 beats streamed -> word 1 held in the output register, word 2 parked, ready_o=0; then ready_i=1 -> both words emitted in order on consecutive cycles and ready_o returns to 1.
REQ-034 SHALL cover: 2 beats accepted, then flush_i for 1 cycle, then 0x01..0x04 -> data_o=0x04030201 with no stale lanes.
REQ-035 SHALL cover: rst_i asserted while valid_o=1 and acc_full=1 -> after the edge valid_o=0, ready_o=1, data_o=0, strb_o=0.
REQ-036 SHALL cover: random valid_i/ready_i over 10k beats -> a scoreboard shows zero beat loss or reordering, and ready_o never depends combinationally on valid_i.
